actor_channel_fifo: RTL and testbench

- Receiving end of the actor output-port protocol (SEND/RDY/ACK/DATA/COUNT).
- Sits between a producer actor's output port (e.g. an adder's Out1) and a consumer actor's input port (SEND/ACK/DATA/COUNT).
- Buffers single-token transfers in a first-word-fall-through FIFO, decoupling producer firing from consumer firing.

---
 rtl/actor_channel_fifo.sv | 89 ++++++++
 tb/tb_actor_channel_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actor_channel_fifo.sv
// Receiving end of an actor output port: buffers single-token SEND/ACK transfers
// in a first-word-fall-through FIFO. Define ACTOR_CHANNEL_FIFO_STATUS_EN to add Occupancy/Overflow outputs.
module actor_channel_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  In_SEND,
    input  logic [DATA_WIDTH-1:0] In_DATA,
    input  logic [15:0]           In_COUNT,
    output logic                  In_RDY,
    output logic                  In_ACK,
    output logic                  Out_SEND,
    output logic [DATA_WIDTH-1:0] Out_DATA,
    output logic [15:0]           Out_COUNT,
    input  logic                  Out_ACK
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
    ,
    output logic [DEPTH_LOG2:0]   Occupancy,
    output logic                  Overflow
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] OCC_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   occ;
    logic                  full;
    logic                  empty;
    logic                  wr;
    logic                  rd;

    // Each transfer carries exactly one token, so the producer count is not needed.
    logic unused_count;
    assign unused_count = ^In_COUNT;

    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign In_RDY    = ~full;
    assign Out_SEND  = ~empty;
    assign wr        = In_SEND & In_RDY;
    assign rd        = Out_ACK & Out_SEND;
    assign In_ACK    = wr;
    assign Out_DATA  = empty ? '0 : mem[rptr];
    assign Out_COUNT = {15'b0, Out_SEND};

    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wptr] <= In_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (rd) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
            case ({wr, rd})
                2'b10:   occ <= occ + (DEPTH_LOG2+1)'(1);
                2'b01:   occ <= occ - (DEPTH_LOG2+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
    assign Occupancy = occ;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Overflow <= 1'b0;
        end else if (In_SEND && !In_RDY) begin
            Overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_actor_channel_fifo.sv
// Scoreboard bench for actor_channel_fifo; the queue holds tokens the bench expects the FIFO to hold.
module tb_actor_channel_fifo;

    logic        CLK;
    logic        RESET;
    logic        In_SEND;
    logic [15:0] In_DATA;
    logic [15:0] In_COUNT;
    logic        In_RDY;
    logic        In_ACK;
    logic        Out_SEND;
    logic [15:0] Out_DATA;
    logic [15:0] Out_COUNT;
    logic        Out_ACK;
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
    logic [4:0]  Occupancy;
    logic        Overflow;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] q[$];

    actor_channel_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .In_SEND   (In_SEND),
        .In_DATA   (In_DATA),
        .In_COUNT  (In_COUNT),
        .In_RDY    (In_RDY),
        .In_ACK    (In_ACK),
        .Out_SEND  (Out_SEND),
        .Out_DATA  (Out_DATA),
        .Out_COUNT (Out_COUNT),
        .Out_ACK   (Out_ACK)
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
        ,
        .Occupancy (Occupancy),
        .Overflow  (Overflow)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of stimulus; handshake outputs are compared with the queue at the falling edge.
    task automatic sb_cycle(input bit send, input logic [15:0] data, input bit ack);
        bit exp_full, exp_empty, exp_wr, exp_rd;
        logic [15:0] exp_head;
        In_SEND  = send;
        In_DATA  = data;
        Out_ACK  = ack;
        In_COUNT = 16'($urandom);
        @(negedge CLK);
        exp_full  = (q.size() == 16);
        exp_empty = (q.size() == 0);
        exp_wr    = send && !exp_full;
        exp_rd    = ack && !exp_empty;
        exp_head  = exp_empty ? 16'h0 : q[0];
        checks++;
        if (In_RDY !== !exp_full) begin
            errors++;
            $display("FAIL in_rdy: got %b want %b (occ %0d)", In_RDY, !exp_full, q.size());
        end
        checks++;
        if (In_ACK !== exp_wr) begin
            errors++;
            $display("FAIL in_ack: got %b want %b (occ %0d)", In_ACK, exp_wr, q.size());
        end
        checks++;
        if (Out_SEND !== !exp_empty) begin
            errors++;
            $display("FAIL out_send: got %b want %b (occ %0d)", Out_SEND, !exp_empty, q.size());
        end
        checks++;
        if (Out_COUNT !== (exp_empty ? 16'h0 : 16'h1)) begin
            errors++;
            $display("FAIL out_count: got %h want %h", Out_COUNT, exp_empty ? 16'h0 : 16'h1);
        end
        checks++;
        if (Out_DATA !== exp_head) begin
            errors++;
            $display("FAIL out_data: got %h want %h", Out_DATA, exp_head);
        end
        @(posedge CLK);
        if (exp_rd) void'(q.pop_front());
        if (exp_wr) q.push_back(data);
        #1;
        In_SEND = 1'b0;
        Out_ACK = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) sb_cycle(1'b0, 16'h0, 1'b1);
        checks++;
        if (Out_SEND !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: out_send %b, model holds %0d want 0", Out_SEND, q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (In_RDY !== 1'b1 || In_ACK !== 1'b0 || Out_SEND !== 1'b0 ||
            Out_COUNT !== 16'h0 || Out_DATA !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy %b ack %b send %b count %h data %h want 1 0 0 0000 0000",
                     In_RDY, In_ACK, Out_SEND, Out_COUNT, Out_DATA);
        end
        RESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single();
        sb_cycle(1'b1, 16'h0005, 1'b0);
        checks++;
        if (Out_SEND !== 1'b1 || Out_DATA !== 16'h0005 || Out_COUNT !== 16'h1) begin
            errors++;
            $display("FAIL single_latency: send %b data %h count %h want 1 0005 0001",
                     Out_SEND, Out_DATA, Out_COUNT);
        end
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) sb_cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        checks++;
        if (In_RDY !== 1'b0) begin
            errors++;
            $display("FAIL full_rdy: got %b want 0", In_RDY);
        end
        sb_cycle(1'b1, 16'hDEAD, 1'b0);
        for (int i = 0; i < 16; i++) begin
            In_SEND = 1'b0;
            Out_ACK = 1'b1;
            #1;
            checks++;
            if (Out_DATA !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("FAIL full_drain_order: got %h want %h", Out_DATA, 16'h0100 + 16'(i));
            end
            sb_cycle(1'b0, 16'h0, 1'b1);
        end
        drain();
    endtask

    task automatic test_full_pop();
        int n;
        for (int i = 0; i < 16; i++) sb_cycle(1'b1, 16'h0200 + 16'(i), 1'b0);
        sb_cycle(1'b1, 16'hBEEF, 1'b1);
        checks++;
        if (In_RDY !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_rdy: got %b want 1", In_RDY);
        end
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
        checks++;
        if (Occupancy !== 5'd15) begin
            errors++;
            $display("FAIL full_pop_occ: got %0d want 15", Occupancy);
        end
`endif
        n = 0;
        for (int i = 0; i < 20 && Out_SEND === 1'b1; i++) begin
            sb_cycle(1'b0, 16'h0, 1'b1);
            n++;
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL full_pop_count: drained %0d want 15", n);
        end
        q.delete();
    endtask

    task automatic test_simul();
        for (int i = 0; i < 5; i++) sb_cycle(1'b1, 16'h0050 + 16'(i), 1'b0);
        sb_cycle(1'b1, 16'h00AA, 1'b1);
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
        checks++;
        if (Occupancy !== 5'd5) begin
            errors++;
            $display("FAIL simul_occ: got %0d want 5", Occupancy);
        end
`endif
        for (int i = 0; i < 4; i++) sb_cycle(1'b0, 16'h0, 1'b1);
        checks++;
        if (Out_DATA !== 16'h00AA || Out_SEND !== 1'b1) begin
            errors++;
            $display("FAIL simul_order: data %h send %b want 00aa 1", Out_DATA, Out_SEND);
        end
        drain();
    endtask

    task automatic test_stream();
        sb_cycle(1'b1, 16'h1000, 1'b0);
        for (int i = 1; i < 40; i++) sb_cycle(1'b1, 16'h1000 + 16'(i), 1'b1);
        drain();
    endtask

    task automatic test_empty_ack();
        for (int i = 0; i < 3; i++) begin
            sb_cycle(1'b0, 16'h0, 1'b1);
            checks++;
            if (Out_SEND !== 1'b0 || Out_COUNT !== 16'h0) begin
                errors++;
                $display("FAIL empty_ack: send %b count %h want 0 0000", Out_SEND, Out_COUNT);
            end
        end
        sb_cycle(1'b1, 16'h0007, 1'b0);
        checks++;
        if (Out_DATA !== 16'h0007) begin
            errors++;
            $display("FAIL empty_then_write: got %h want 0007", Out_DATA);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) sb_cycle(1'b1, 16'h0300 + 16'(i), 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (Out_SEND !== 1'b0 || In_RDY !== 1'b1 || Out_DATA !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: send %b rdy %b data %h want 0 1 0000", Out_SEND, In_RDY, Out_DATA);
        end
        q.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        sb_cycle(1'b0, 16'h0, 1'b1);
        sb_cycle(1'b1, 16'h0042, 1'b0);
        drain();
    endtask

`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
    task automatic test_status();
        RESET = 1'b1;
        #1;
        q.delete();
        RESET = 1'b0;
        checks++;
        if (Overflow !== 1'b0 || Occupancy !== 5'd0) begin
            errors++;
            $display("FAIL status_reset: ovf %b occ %0d want 0 0", Overflow, Occupancy);
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < 16; i++) sb_cycle(1'b1, 16'h0400 + 16'(i), 1'b0);
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL status_no_ovf: got %b want 0", Overflow);
        end
        sb_cycle(1'b1, 16'hDEAD, 1'b0);
        checks++;
        if (Overflow !== 1'b1) begin
            errors++;
            $display("FAIL status_ovf: got %b want 1", Overflow);
        end
        drain();
        checks++;
        if (Overflow !== 1'b1) begin
            errors++;
            $display("FAIL status_ovf_sticky: got %b want 1", Overflow);
        end
    endtask
`endif

    initial begin
        RESET    = 1'b1;
        In_SEND  = 1'b0;
        In_DATA  = 16'h0;
        In_COUNT = 16'h0;
        Out_ACK  = 1'b0;
        #12;
        test_reset();
        test_single();
        test_full();
        test_full_pop();
        test_simul();
        test_stream();
        test_empty_ack();
        test_reset_mid();
`ifdef ACTOR_CHANNEL_FIFO_STATUS_EN
        test_status();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
